maxnet_core: RTL and testbench
==============================

# maxnet_core

Iterative winner-take-all datapath that sits directly downstream of the load/sequence controller. It holds four candidate activations x0..x3 and four inhibition weights w0..w3, loaded from data memory under controller enables. On each `strt` pulse it computes one lateral-inhibition step serially and pulses `done1`. It then reports `done` (a single survivor remains) and `max` (the winning index), which the controller uses as the final memory read address.

## Interface
- `DW`, 8: width of activations, weights and `din`.
- `FRAC`, 8: fractional bits of the weights; each weight is an unsigned Q0.FRAC value.
- `MAX_ITER`, 64: iteration cap. Used only with `MAXNET_ITER_LIMIT_EN`.
- `clk` in 1: clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `din` in DW: memory read data.
- `sel` in 1: 1 loads `din`; 0 commits computed values.
- `xe` in 4: per-neuron activation write enables (bit i = x_i).
- `we` in 4: per-neuron weight load enables (bit i = w_i), always from `din`.
- `strt` in 1: start one iteration.
- `done1` out 1: one-cycle pulse when an iteration's results are ready.
- `done` out 1: convergence flag, meaningful after `done1`.
- `max` out 3: winning index, 0..3; bit 2 is always 0.

## Operation
- States: IDLE, SUM, UPD0, UPD1, UPD2, UPD3, FIN.
  - IDLE goes to SUM on `strt`.
  - SUM, UPD0, UPD1 and UPD2 each go to the next state unconditionally.
  - UPD3 goes to FIN. FIN goes to IDLE.
- SUM: register S = x0+x1+x2+x3, width DW+2.
- UPDi:
  - o = S − x_i.
  - inh = (w_i · o) >> FRAC, with a full-width product and truncation.
  - sh_i = (inh ≥ x_i) ? 0 : x_i − inh.
  - Write sh_i to shadow register i.
- FIN: `done1` = 1. Set `vld`; increment `iter_cnt`, saturating.
- `strt` outside IDLE is ignored. `strt` in IDLE clears `vld`.
- Write to x_i when `xe[i]`:
  - `sel` = 1: x_i ← `din`.
  - `sel` = 0: x_i ← sh_i.
  - Multiple `xe` bits may be asserted together.
  - Any `xe` with `sel` = 1 also clears `iter_cnt` and `vld`.
- Write to w_i when `we[i]`: w_i ← `din`, regardless of `sel`.
- `max` is the argmax over the shadow registers; the lowest index wins ties. It is 0 when all shadows are 0.
- `done` = `vld` && (number of nonzero sh_i ≤ 1). All shadows zero gives `done` = 1.
- `done` and `max` are combinational from `vld` and the shadow registers. They are held until the next `strt` or load.
- Reset value of all registers is 0: x, w, sh, S, `iter_cnt`, `vld`, and state = IDLE.
- After reset: `done1` = 0, `done` = 0, `max` = 0.
- Reset mid-iteration aborts to IDLE on the next edge. No `done1` is produced.

## Timing
- `strt` high in cycle t gives SUM at t+1, UPD0..UPD3 at t+2..t+5, and `done1` high at t+6.
- `vld` = 1 from t+7. The controller's check cycle, which follows `done1`, sees a valid `done`/`max` and may commit with `xe` = 4'b1111, `sel` = 0.
- Commit and `din` loads take effect at the next edge. Shadow registers are not modified by commits.
- Minimum iteration period with a controller round trip: 8 cycles.

## Configuration
- `MAXNET_ITER_LIMIT_EN` defined:
  - `iter_cnt` (8 bits) is implemented.
  - `done` is also forced to 1 when `vld` && `iter_cnt` == `MAX_ITER`.
  - `max` is still the argmax. This guarantees termination when truncation stalls the inhibition.
- `MAXNET_ITER_LIMIT_EN` undefined:
  - No counter.
  - `done` depends only on the nonzero count, so a stalled tie never terminates.

## Test plan
- Nominal step: load x = {10,40,20,30} and w = 32 for all (0.125), then `strt`.
  - `done1` at t+6.
  - Shadows = {0,33,10,22}.
  - `done` = 0, `max` = 1.
- Single survivor: x = {0,0,50,0}, w = 32, `strt`.
  - Shadows = {0,0,50,0}.
  - `done` = 1, `max` = 2.
- All zero: x = {0,0,0,0}, `strt`.
  - `done` = 1, `max` = 0.
  - Before any `strt`, `done` = 0.
- Stalled tie: x = {7,7,0,0}, w = 32, repeated `strt` + commit.
  - Shadows stay {7,7,0,0}.
  - With the macro and `MAX_ITER` = 4: `done` = 1 after the 4th `done1`, `max` = 0.
  - Without the macro: `done` stays 0.
- Protocol: `strt` asserted during UPD1 is ignored, giving exactly one `done1`. `rst` asserted in UPD2 gives no `done1`, state IDLE, and all outputs 0.
- Commit path: after the nominal step, assert `xe` = 4'b1111 with `sel` = 0, then `strt`.
  - S = 65.
  - Shadows = {0,29,4,17}.
  - `max` = 1.

Source files
------------

// File: rtl/maxnet_core.sv
// Winner-take-all datapath: one serial lateral-inhibition step per strt pulse.
// Define MAXNET_ITER_LIMIT_EN to add the iteration cap that forces done.
module maxnet_core #(
  parameter int DW       = 8,
  parameter int FRAC     = 8,
  parameter int MAX_ITER = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] din,
  input  logic          sel,
  input  logic [3:0]    xe,
  input  logic [3:0]    we,
  input  logic          strt,
  output logic          done1,
  output logic          done,
  output logic [2:0]    max
);

  typedef enum logic [2:0] {IDLE, SUM, UPD0, UPD1, UPD2, UPD3, FIN} state_t;

  state_t        state;
  logic [DW-1:0] x  [4];
  logic [DW-1:0] w  [4];
  logic [DW-1:0] sh [4];
  logic [DW+1:0] s;
  logic          vld;
`ifdef MAXNET_ITER_LIMIT_EN
  logic [7:0]    iter_cnt;
`endif

  logic [1:0]      idx;
  logic [DW-1:0]   x_cur;
  logic [DW-1:0]   w_cur;
  logic [DW-1:0]   sh_next;
  logic [DW+1:0]   o;
  logic [2*DW+1:0] prod;
  logic [2*DW+1:0] inh;

  // One shared multiplier serves the neuron selected by the current UPD state.
  always_comb begin
    case (state)
      UPD1:    idx = 2'd1;
      UPD2:    idx = 2'd2;
      UPD3:    idx = 2'd3;
      default: idx = 2'd0;
    endcase
    x_cur = x[idx];
    w_cur = w[idx];
    o     = s - {2'b00, x_cur};
    prod  = {{(DW+2){1'b0}}, w_cur} * {{DW{1'b0}}, o};
    inh   = prod >> FRAC;
    if (inh >= {{(DW+2){1'b0}}, x_cur})
      sh_next = '0;
    else
      sh_next = x_cur - inh[DW-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      done1 <= 1'b0;
      vld   <= 1'b0;
      s     <= '0;
      for (int i = 0; i < 4; i++) begin
        x[i]  <= '0;
        w[i]  <= '0;
        sh[i] <= '0;
      end
`ifdef MAXNET_ITER_LIMIT_EN
      iter_cnt <= '0;
`endif
    end else begin
      done1 <= 1'b0;
      case (state)
        IDLE: if (strt) begin
          state <= SUM;
          vld   <= 1'b0;
        end
        SUM: begin
          s     <= {2'b00, x[0]} + {2'b00, x[1]} + {2'b00, x[2]} + {2'b00, x[3]};
          state <= UPD0;
        end
        UPD0: begin sh[0] <= sh_next; state <= UPD1; end
        UPD1: begin sh[1] <= sh_next; state <= UPD2; end
        UPD2: begin sh[2] <= sh_next; state <= UPD3; end
        UPD3: begin
          sh[3] <= sh_next;
          done1 <= 1'b1;
          state <= FIN;
        end
        FIN: begin
          vld   <= 1'b1;
`ifdef MAXNET_ITER_LIMIT_EN
          if (iter_cnt != 8'hFF)
            iter_cnt <= iter_cnt + 8'd1;
`endif
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      for (int i = 0; i < 4; i++) begin
        if (xe[i]) x[i] <= sel ? din : sh[i];
        if (we[i]) w[i] <= din;
      end
      // A fresh load starts a new competition, so prior results are void.
      if (sel && (|xe)) begin
        vld <= 1'b0;
`ifdef MAXNET_ITER_LIMIT_EN
        iter_cnt <= '0;
`endif
      end
    end
  end

  logic [2:0]    nz;
  logic [DW-1:0] best;
  logic [1:0]    win;

  // Strict greater-than keeps the lowest index on ties.
  always_comb begin
    nz   = '0;
    best = '0;
    win  = '0;
    for (int i = 0; i < 4; i++) begin
      if (sh[i] != '0) nz = nz + 3'd1;
      if (sh[i] > best) begin
        best = sh[i];
        win  = 2'(i);
      end
    end
    done = vld && (nz <= 3'd1);
`ifdef MAXNET_ITER_LIMIT_EN
    if (vld && (iter_cnt == 8'(MAX_ITER))) done = 1'b1;
`endif
    max = {1'b0, win};
  end

endmodule

// File: tb/tb_maxnet_core.sv
// Scoreboard bench for maxnet_core: directed vectors with hand-computed results.
// Built with MAX_ITER = 4 so the optional iteration cap is reachable.
module tb_maxnet_core;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] din;
  logic       sel;
  logic [3:0] xe;
  logic [3:0] we;
  logic       strt;
  logic       done1;
  logic       done;
  logic [2:0] max;

  maxnet_core #(.DW(8), .FRAC(8), .MAX_ITER(4)) dut (
    .clk(clk), .rst(rst), .din(din), .sel(sel), .xe(xe), .we(we),
    .strt(strt), .done1(done1), .done(done), .max(max)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic            done;
    logic [2:0]      max;
    logic [31:0]     start;
    logic [3:0][7:0] sh;
  } exp_t;

  exp_t sb[$];
  int vec_cnt  = 0;
  int miss_cnt = 0;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    vec_cnt++;
    if (act !== req) begin
      miss_cnt++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  function automatic logic [3:0][7:0] pack_sh(input logic [7:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic [3:0] xe_v, input logic [3:0] we_v,
                                input logic sel_v, input logic [7:0] din_v, input logic strt_v);
    xe = xe_v; we = we_v; sel = sel_v; din = din_v; strt = strt_v;
    next_cycle();
    xe = '0; we = '0; sel = 1'b0; din = '0; strt = 1'b0;
  endtask

  task automatic load_x(input logic [7:0] a, b, c, d);
    apply_stimulus(4'b0001, 4'b0000, 1'b1, a, 1'b0);
    apply_stimulus(4'b0010, 4'b0000, 1'b1, b, 1'b0);
    apply_stimulus(4'b0100, 4'b0000, 1'b1, c, 1'b0);
    apply_stimulus(4'b1000, 4'b0000, 1'b1, d, 1'b0);
  endtask

  task automatic commit();
    apply_stimulus(4'b1111, 4'b0000, 1'b0, 8'd0, 1'b0);
  endtask

  task automatic run_iter(input logic exp_done, input logic [2:0] exp_max, input logic [3:0][7:0] exp_sh);
    exp_t e;
    e.done  = exp_done;
    e.max   = exp_max;
    e.start = 32'(cyc);
    e.sh    = exp_sh;
    sb.push_back(e);
    apply_stimulus(4'b0000, 4'b0000, 1'b0, 8'd0, 1'b1);
    repeat (7) next_cycle();
    check_output("done1_seen", 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  // Monitor: pops one expectation per done1 and checks results a cycle later.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done1 === 1'b1) begin
        if (sb.size() == 0) begin
          vec_cnt++;
          miss_cnt++;
          $display("[TB] FAIL unexpected_done1: got done1=1 at cycle %0d, expected none", cyc);
        end else begin
          e = sb.pop_front();
          check_output("latency", 32'(cyc) - e.start, 32'd6);
          @(negedge clk);
          check_output("done", 32'(done), 32'(e.done));
          check_output("max", 32'(max), 32'(e.max));
          for (int i = 0; i < 4; i++)
            check_output($sformatf("sh%0d", i), 32'(dut.sh[i]), 32'(e.sh[i]));
        end
      end
    end
  end

  initial begin
    logic stall_done;
    rst = 1'b1; din = '0; sel = 1'b0; xe = '0; we = '0; strt = 1'b0;
    repeat (2) next_cycle();
    check_output("rst_done1", 32'(done1), 32'd0);
    check_output("rst_done", 32'(done), 32'd0);
    check_output("rst_max", 32'(max), 32'd0);
    rst = 1'b0;
    next_cycle();

    // Nominal step then commit path
    load_x(8'd10, 8'd40, 8'd20, 8'd30);
    apply_stimulus(4'b0000, 4'b1111, 1'b1, 8'd32, 1'b0);
    check_output("pre_strt_done", 32'(done), 32'd0);
    run_iter(1'b0, 3'd1, pack_sh(8'd0, 8'd33, 8'd10, 8'd22));
    commit();
    run_iter(1'b0, 3'd1, pack_sh(8'd0, 8'd29, 8'd4, 8'd17));

    // Single survivor
    load_x(8'd0, 8'd0, 8'd50, 8'd0);
    run_iter(1'b1, 3'd2, pack_sh(8'd0, 8'd0, 8'd50, 8'd0));

    // All zero
    load_x(8'd0, 8'd0, 8'd0, 8'd0);
    check_output("load_clears_done", 32'(done), 32'd0);
    run_iter(1'b1, 3'd0, pack_sh(8'd0, 8'd0, 8'd0, 8'd0));

    // Stalled tie
    load_x(8'd7, 8'd7, 8'd0, 8'd0);
    for (int k = 1; k <= 4; k++) begin
`ifdef MAXNET_ITER_LIMIT_EN
      stall_done = (k == 4);
`else
      stall_done = 1'b0;
`endif
      run_iter(stall_done, 3'd0, pack_sh(8'd7, 8'd7, 8'd0, 8'd0));
      commit();
    end

    // strt during UPD1 must be ignored
    load_x(8'd10, 8'd40, 8'd20, 8'd30);
    begin
      exp_t e;
      e.done  = 1'b0;
      e.max   = 3'd1;
      e.start = 32'(cyc);
      e.sh    = pack_sh(8'd0, 8'd33, 8'd10, 8'd22);
      sb.push_back(e);
    end
    apply_stimulus(4'b0000, 4'b0000, 1'b0, 8'd0, 1'b1);
    repeat (2) next_cycle();
    apply_stimulus(4'b0000, 4'b0000, 1'b0, 8'd0, 1'b1);
    repeat (4) next_cycle();
    check_output("ignored_strt_done1", 32'(sb.size()), 32'd0);
    sb.delete();
    repeat (10) next_cycle();

    // Reset asserted in UPD2 aborts the iteration
    apply_stimulus(4'b0000, 4'b0000, 1'b0, 8'd0, 1'b1);
    repeat (3) next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    repeat (6) next_cycle();
    check_output("abort_state", 32'(dut.state), 32'd0);
    check_output("abort_done1", 32'(done1), 32'd0);
    check_output("abort_done", 32'(done), 32'd0);
    check_output("abort_max", 32'(max), 32'd0);
    for (int i = 0; i < 4; i++)
      check_output($sformatf("abort_sh%0d", i), 32'(dut.sh[i]), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
